// File: rtl/xusb_pkg.sv
// Shared definitions for the USB-style stream FIFO.
//   DW_DEFAULT / AW_DEFAULT : default data and address widths
//   state_t                 : stream life-cycle state encoding
package xusb_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EOF   = 2'd3
  } state_t;

endpackage

// File: rtl/xusb_sdp_ram.sv
// Simple dual-port RAM, DW x 2**AW, one write port and one registered read port.
//   clk, rst_n        : clock, async active-low reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/addr        : read request; rd_data updates on the next edge and holds otherwise
module xusb_sdp_ram
  import xusb_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage array carries no reset; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read output, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/xusb_stream_fifo.sv
// Host stream FIFO with open/drain/end-of-file tracking.
//   bus_clk, bus_rst_n       : clock, async active-low reset
//   w_open, w_wren, w_data   : host write stream (open flag, strobe, data)
//   w_full                   : no room for a write (registered)
//   r_open, r_rden           : host read stream (open flag, strobe)
//   r_data                   : read data, valid the edge after an accepted read
//   r_empty, r_eof           : no data / end-of-file to reader (registered)
//   level                    : words stored (registered)
//   overflow                 : sticky, set by a write dropped while full
module xusb_stream_fifo
  import xusb_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          bus_clk,
  input  logic          bus_rst_n,
  input  logic          w_open,
  input  logic          w_wren,
  input  logic [DW-1:0] w_data,
  output logic          w_full,
  input  logic          r_open,
  input  logic          r_rden,
  output logic [DW-1:0] r_data,
  output logic          r_empty,
  output logic          r_eof,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 2**AW;

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          w_open_q, r_open_q;
  logic          flush, open_rise, drop, wr_acc, rd_acc;
  logic [AW:0]   level_next;

  // Next-state and datapath decisions; flush is resolved first because it
  // overrides both accepts and the level update.
  always_comb begin
    flush      = 1'b0;
    open_rise  = 1'b0;
    drop       = 1'b0;
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;
    level_next = level;
    state_next = state;

    if ((state == ST_EOF) && !w_open && !r_open) flush = 1'b1;
    if ((state == ST_IDLE) && r_open_q && !r_open) flush = 1'b1;

    open_rise  = w_open & ~w_open_q;
    drop       = w_wren & w_full;
    wr_acc     = w_wren & ~w_full & ~flush;
    rd_acc     = r_rden & ~r_empty & ~flush;
    level_next = flush ? '0 : (level + LW'(wr_acc) - LW'(rd_acc));

    case (state)
      ST_IDLE:  if (w_open) state_next = ST_OPEN;
      ST_OPEN:  if (!w_open) state_next = (level != '0) ? ST_DRAIN : ST_EOF;
      ST_DRAIN: begin
        if (w_open)                 state_next = ST_OPEN;
        else if (level_next == '0)  state_next = ST_EOF;
      end
      ST_EOF: begin
        if (w_open)       state_next = ST_OPEN;
        else if (!r_open) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Pointers, level, flags; all flags derive from next-cycle values so they
  // change on the same edge as level.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      w_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_eof    <= 1'b0;
      overflow <= 1'b0;
      w_open_q <= 1'b0;
      r_open_q <= 1'b0;
    end else begin
      w_open_q <= w_open;
      r_open_q <= r_open;
      level    <= level_next;
      w_full   <= (level_next == LW'(DEPTH));
      r_empty  <= (level_next == '0);
      r_eof    <= (state_next == ST_EOF) && (level_next == '0);
      // A drop in the same cycle as reopening still counts as an overflow.
      overflow <= (overflow & ~open_rise) | drop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  xusb_sdp_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (bus_clk),
    .rst_n   (bus_rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (w_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (r_data)
  );

endmodule

// File: tb/tb_xusb_stream_fifo.sv
// Self-checking bench for xusb_stream_fifo (DW=32, AW=4): directed scenarios
// with literal expectations, then randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_xusb_stream_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
  localparam int M_IDLE = 0, M_OPEN = 1, M_DRAIN = 2, M_EOF = 3;

  logic          bus_clk   = 1'b0;
  logic          bus_rst_n = 1'b0;
  logic          w_open    = 1'b0;
  logic          w_wren    = 1'b0;
  logic [DW-1:0] w_data    = '0;
  logic          r_open    = 1'b0;
  logic          r_rden    = 1'b0;
  logic          w_full;
  logic [DW-1:0] r_data;
  logic          r_empty;
  logic          r_eof;
  logic [AW:0]   level;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  xusb_stream_fifo #(.DW(DW), .AW(AW)) dut (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .w_open    (w_open),
    .w_wren    (w_wren),
    .w_data    (w_data),
    .w_full    (w_full),
    .r_open    (r_open),
    .r_rden    (r_rden),
    .r_data    (r_data),
    .r_empty   (r_empty),
    .r_eof     (r_eof),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 bus_clk = ~bus_clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata;
  bit            m_ov;
  int            m_st;
  bit            m_wq, m_rq;

  task automatic model_reset();
    mq.delete();
    m_rdata = '0;
    m_ov    = 1'b0;
    m_st    = M_IDLE;
    m_wq    = 1'b0;
    m_rq    = 1'b0;
  endtask

  task automatic model_step();
    int old_n;
    bit fl, rise;
    old_n = mq.size();
    fl    = (m_st == M_EOF && !w_open && !r_open) || (m_st == M_IDLE && m_rq && !r_open);
    rise  = w_open && !m_wq;
    if (w_wren && old_n == DEPTH) m_ov = 1'b1;
    else if (rise)                m_ov = 1'b0;
    if (fl) mq.delete();
    else begin
      if (r_rden && old_n != 0)     m_rdata = mq.pop_front();
      if (w_wren && old_n != DEPTH) mq.push_back(w_data);
    end
    case (m_st)
      M_IDLE:  if (w_open) m_st = M_OPEN;
      M_OPEN:  if (!w_open) m_st = (old_n > 0) ? M_DRAIN : M_EOF;
      M_DRAIN: if (w_open) m_st = M_OPEN; else if (mq.size() == 0) m_st = M_EOF;
      default: if (w_open) m_st = M_OPEN; else if (!r_open) m_st = M_IDLE;
    endcase
    m_wq = w_open;
    m_rq = r_open;
  endtask

  always @(posedge bus_clk) if (bus_rst_n) model_step();

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge bus_clk) begin
    chk("level",    64'(level),    64'(mq.size()));
    chk("w_full",   64'(w_full),   64'(mq.size() == DEPTH));
    chk("r_empty",  64'(r_empty),  64'(mq.size() == 0));
    chk("r_eof",    64'(r_eof),    64'(m_st == M_EOF && mq.size() == 0));
    chk("overflow", 64'(overflow), 64'(m_ov));
    chk("r_data",   64'(r_data),   64'(m_rdata));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge bus_clk);
  endtask

  task automatic write_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      w_wren = 1'b1;
      w_data = DW'(base + i);
      tick();
    end
    w_wren = 1'b0;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      r_rden = 1'b1;
      tick();
    end
    r_rden = 1'b0;
  endtask

  // Reset asserted off the clock edges; model reset alongside.
  task automatic pulse_reset();
    #2;
    bus_rst_n = 1'b0;
    model_reset();
    #1;
    tick();
    #2;
    bus_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int pw;
    model_reset();
    repeat (2) tick();
    chk("rst_level",   64'(level),    64'd0);
    chk("rst_empty",   64'(r_empty),  64'd1);
    chk("rst_full",    64'(w_full),   64'd0);
    chk("rst_eof",     64'(r_eof),    64'd0);
    chk("rst_ovf",     64'(overflow), 64'd0);
    chk("rst_rdata",   64'(r_data),   64'd0);
    #2 bus_rst_n = 1'b1;
    tick();

    // Fill to full, then one dropped write.
    w_open = 1'b1;
    r_open = 1'b1;
    write_n(16, 1);
    chk("fill_full",  64'(w_full),   64'd1);
    chk("fill_level", 64'(level),    64'd16);
    chk("fill_ovf0",  64'(overflow), 64'd0);
    write_n(1, 17);
    chk("drop_ovf",   64'(overflow), 64'd1);
    chk("drop_level", 64'(level),    64'd16);

    // Read back in order, one word per cycle.
    for (int i = 0; i < 16; i++) begin
      r_rden = 1'b1;
      tick();
      chk("order_data", 64'(r_data), 64'(i + 1));
    end
    r_rden = 1'b0;
    chk("order_empty", 64'(r_empty), 64'd1);

    // Simultaneous read and write while full.
    write_n(16, 32'h20);
    w_wren = 1'b1;
    w_data = 32'h99;
    r_rden = 1'b1;
    tick();
    w_wren = 1'b0;
    r_rden = 1'b0;
    chk("sim_level", 64'(level),  64'd15);
    chk("sim_data",  64'(r_data), 64'h20);
    chk("sim_full",  64'(w_full), 64'd0);
    read_n(15);
    chk("sim_last",  64'(r_data), 64'h2f);
    chk("sim_empty", 64'(r_empty), 64'd1);

    // Drain and end-of-file.
    write_n(3, 32'h31);
    w_open = 1'b0;
    tick();
    chk("eof_drain_st", 64'(m_st), 64'(M_DRAIN));
    chk("eof_pre0",     64'(r_eof), 64'd0);
    r_rden = 1'b1;
    tick();
    chk("eof_pre1", 64'(r_eof), 64'd0);
    tick();
    chk("eof_pre2", 64'(r_eof), 64'd0);
    tick();
    r_rden = 1'b0;
    chk("eof_set",   64'(r_eof),   64'd1);
    chk("eof_empty", 64'(r_empty), 64'd1);
    chk("eof_data",  64'(r_data),  64'h33);
    chk("eof_st",    64'(m_st),    64'(M_EOF));
    r_open = 1'b0;
    tick();
    chk("idle_st",  64'(m_st),  64'(M_IDLE));
    chk("idle_eof", 64'(r_eof), 64'd0);

    // Read while empty is ignored.
    r_open = 1'b1;
    r_rden = 1'b1;
    tick();
    r_rden = 1'b0;
    chk("empty_rd_data",  64'(r_data), 64'h33);
    chk("empty_rd_level", 64'(level),  64'd0);

    // Reset mid-stream with overflow set and level 7.
    w_open = 1'b1;
    write_n(17, 32'h40);
    read_n(9);
    chk("mid_level", 64'(level),    64'd7);
    chk("mid_ovf",   64'(overflow), 64'd1);
    #2;
    bus_rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_level", 64'(level),    64'd0);
    chk("mrst_empty", 64'(r_empty),  64'd1);
    chk("mrst_ovf",   64'(overflow), 64'd0);
    chk("mrst_rdata", 64'(r_data),   64'd0);
    chk("mrst_st",    64'(m_st),     64'(M_IDLE));
    tick();
    #2 bus_rst_n = 1'b1;
    tick();

    // Randomized traffic in write-heavy / read-heavy / balanced phases.
    for (int c = 0; c < 4000; c++) begin
      pw     = ((c / 150) % 3 == 0) ? 75 : (((c / 150) % 3 == 1) ? 25 : 50);
      w_wren = ($urandom_range(0, 99) < pw);
      r_rden = ($urandom_range(0, 99) < (100 - pw));
      w_data = $urandom;
      if ($urandom_range(0, 39) == 0) w_open = ~w_open;
      if ($urandom_range(0, 29) == 0) r_open = ~r_open;
      if ($urandom_range(0, 1499) == 0) pulse_reset();
      else tick();
    end

    w_wren = 1'b0;
    r_rden = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
